sbox_ddt_row_scanner: RTL and testbench

- Sequential analysis stage sitting directly downstream of the 6-bit GF(2^6) S-box evaluators (SMS32 power-map S-boxes).
- For a given input difference delta, sweeps x = 0..63, drives x and x^delta into two external combinational S-box instances, and histograms y0^y1 into 64 counters (one DDT row).
- Scans the row, reports the maximum entry and its output difference, and exposes the row for readback.

---
 rtl/sbox_ddt_row_scanner_if.sv | 29 ++
 rtl/sbox_ddt_row_scanner.sv | 133 +++++++++++++
 tb/tb_sbox_ddt_row_scanner.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_ddt_row_scanner_if.sv
// Bus between the DDT row scanner and its host: control handshake, S-box
// evaluator pair connection and result/readback signals.
interface sbox_ddt_row_scanner_if #(
  parameter int WIDTH = 6,
  parameter int CW    = WIDTH + 1
);
  logic             start;
  logic [WIDTH-1:0] delta;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sbox_x0;
  logic [WIDTH-1:0] sbox_x1;
  logic [WIDTH-1:0] sbox_y0;
  logic [WIDTH-1:0] sbox_y1;
  logic [CW-1:0]    max_count;
  logic [WIDTH-1:0] max_diff;
  logic [WIDTH-1:0] rd_addr;
  logic [CW-1:0]    rd_count;

  modport master (
    output start, delta, sbox_y0, sbox_y1, rd_addr,
    input  busy, done, sbox_x0, sbox_x1, max_count, max_diff, rd_count
  );

  modport slave (
    input  start, delta, sbox_y0, sbox_y1, rd_addr,
    output busy, done, sbox_x0, sbox_x1, max_count, max_diff, rd_count
  );
endinterface

// File: rtl/sbox_ddt_row_scanner.sv
// Computes one difference-distribution-table row of an external S-box pair
// for a captured input difference, then scans it for the maximum entry.
module sbox_ddt_row_scanner #(
  parameter int WIDTH = 6,
  parameter int CW    = WIDTH + 1
) (
  input logic                  clk,
  input logic                  rst,
  sbox_ddt_row_scanner_if.slave bus
);
  localparam int               ENTRIES = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, SCAN, DONE} state_t;

  state_t                      state_q;
  logic [WIDTH-1:0]            delta_q;
  logic [WIDTH-1:0]            idx_q;
  logic [WIDTH-1:0]            x0_q;
  logic [WIDTH-1:0]            x1_q;
  logic [WIDTH-1:0]            d_q;
  logic                        vld_q;
  logic                        busy_q;
  logic                        done_q;
  logic [ENTRIES-1:0][CW-1:0]  cnt_q;
  logic [CW-1:0]               best_q;
  logic [WIDTH-1:0]            best_idx_q;
  logic [CW-1:0]               max_count_q;
  logic [WIDTH-1:0]            max_diff_q;

  logic [WIDTH-1:0]            idx_d;
  logic [WIDTH-1:0]            diff_d;
  logic [CW-1:0]               scan_cnt;
  logic                        scan_gt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(ENTRIES)) ? c : c + CW'(1);
  endfunction

  always_comb begin
    idx_d    = idx_q + WIDTH'(1);
    diff_d   = bus.sbox_y0 ^ bus.sbox_y1;
    scan_cnt = cnt_q[idx_q];
    scan_gt  = scan_cnt > best_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      delta_q     <= '0;
      idx_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      d_q         <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      max_count_q <= '0;
      max_diff_q  <= '0;
    end else begin
      // Histogram stage: the difference registered last cycle lands in its bin.
      // vld_q is never set in IDLE, so this cannot collide with the clear.
      if (vld_q) cnt_q[d_q] <= sat_inc(cnt_q[d_q]);

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            delta_q     <= bus.delta;
            cnt_q       <= '0;
            idx_q       <= '0;
            x0_q        <= '0;
            x1_q        <= bus.delta;
            busy_q      <= 1'b1;
            max_count_q <= '0;
            max_diff_q  <= '0;
            state_q     <= SWEEP;
          end
        end
        SWEEP: begin
          // Sample stage: capture the output difference for the index on the S-boxes.
          d_q   <= diff_d;
          vld_q <= 1'b1;
          if (idx_q == LAST) begin
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_d;
            x0_q  <= idx_d;
            x1_q  <= idx_d ^ delta_q;
          end
        end
        DRAIN: begin
          vld_q      <= 1'b0;
          idx_q      <= '0;
          best_q     <= '0;
          best_idx_q <= '0;
          state_q    <= SCAN;
        end
        SCAN: begin
          // Strict compare keeps the lowest index among equal maxima.
          if (scan_gt) begin
            best_q     <= scan_cnt;
            best_idx_q <= idx_q;
          end
          if (idx_q == LAST) begin
            max_count_q <= scan_gt ? scan_cnt : best_q;
            max_diff_q  <= scan_gt ? idx_q : best_idx_q;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sbox_x0   = x0_q;
  assign bus.sbox_x1   = x1_q;
  assign bus.max_count = max_count_q;
  assign bus.max_diff  = max_diff_q;
  assign bus.rd_count  = cnt_q[bus.rd_addr];
endmodule

// File: tb/tb_sbox_ddt_row_scanner.sv
// Scoreboard bench for the DDT row scanner: random runs over identity,
// constant and GF(2^6) power-52 S-boxes against a software DDT model.
module tb_sbox_ddt_row_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;

  sbox_ddt_row_scanner_if #(.WIDTH(6), .CW(7)) bus();

  sbox_ddt_row_scanner #(.WIDTH(6), .CW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // S-box tables: 0 identity, 1 constant 0x2A, 2 x^52 over GF(2)[x]/(x^6+x+1)
  logic [5:0] lut [3][64];
  int unsigned mode_r = 0;

  assign bus.sbox_y0 = lut[mode_r][bus.sbox_x0];
  assign bus.sbox_y1 = lut[mode_r][bus.sbox_x1];

  typedef struct packed {
    logic [63:0][6:0] row;
    logic [6:0]       mc;
    logic [5:0]       md;
    int unsigned      acc;
    logic             chk_row;
  } exp_t;

  exp_t sb[$];
  logic mon_idle = 1'b1;

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] gf_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = gf_mul(r, x);
    return r;
  endfunction

  function automatic exp_t model(input int m, input logic [5:0] d,
                                 input int unsigned acc, input logic chk_row);
    exp_t       e;
    int         cnt [64];
    int         mx;
    logic [5:0] xv;
    logic [5:0] dv;
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    for (int x = 0; x < 64; x++) begin
      xv = 6'(x);
      dv = lut[m][xv] ^ lut[m][xv ^ d];
      cnt[dv] = cnt[dv] + 1;
    end
    mx = 0;
    for (int i = 0; i < 64; i++) if (cnt[i] > mx) mx = cnt[i];
    e = '0;
    for (int i = 63; i >= 0; i--) if (cnt[i] == mx) e.md = 6'(i);
    for (int i = 0; i < 64; i++) e.row[i] = 7'(cnt[i]);
    e.mc      = 7'(mx);
    e.acc     = acc;
    e.chk_row = chk_row;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
  endtask

  // Monitor: pops an expectation on every done pulse and reads back the row
  initial begin
    exp_t e;
    int   sum;
    bus.rd_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        mon_idle = 1'b0;
        if (sb.size() == 0) begin
          chk("done_without_start", int'(bus.done), 0);
        end else begin
          e = sb.pop_front();
          chk("max_count", int'(bus.max_count), int'(e.mc));
          chk("max_diff", int'(bus.max_diff), int'(e.md));
          chk("done_latency", int'(cyc - e.acc), 129);
          chk("busy_at_done", int'(bus.busy), 1);
          @(negedge clk);
          chk("done_pulse_width", int'(bus.done), 0);
          chk("busy_after_done", int'(bus.busy), 0);
          if (e.chk_row) begin
            sum = 0;
            for (int a = 0; a < 64; a++) begin
              bus.rd_addr = 6'(a);
              #1;
              chk($sformatf("row[%0d]", a), int'(bus.rd_count), int'(e.row[a]));
              sum += int'(bus.rd_count);
              @(negedge clk);
            end
            chk("row_sum", sum, 64);
          end
        end
        mon_idle = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !mon_idle) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait_bound", int'(t < 600), 1);
  endtask

  task automatic wait_not_busy();
    int t = 0;
    while (bus.busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("busy_wait_bound", int'(t < 300), 1);
  endtask

  task automatic run_row(input int m, input logic [5:0] d, input logic chk_row);
    int hold;
    wait_idle();
    @(negedge clk);
    mode_r    = m;
    bus.delta = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(m, d, cyc, chk_row));
    chk("busy_on_accept", int'(bus.busy), 1);
    hold = $urandom_range(0, 60);
    repeat (hold) begin
      @(negedge clk);
      bus.delta = 6'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.delta = 6'($urandom);
    wait_not_busy();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_max_count"}, int'(bus.max_count), 0);
    chk({tag, "_max_diff"}, int'(bus.max_diff), 0);
    chk({tag, "_sbox_x0"}, int'(bus.sbox_x0), 0);
    chk({tag, "_sbox_x1"}, int'(bus.sbox_x1), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    for (int i = 0; i < 64; i++) begin
      lut[0][i] = 6'(i);
      lut[1][i] = 6'h2A;
      lut[2][i] = gf_pow(6'(i), 52);
    end
    bus.start = 1'b0;
    bus.delta = '0;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_rd_count0", int'(bus.rd_count), 0);
    @(negedge clk);
    rst = 1'b0;

    run_row(0, 6'h15, 1'b1);
    run_row(1, 6'h3F, 1'b1);
    run_row(2, 6'h00, 1'b1);
    for (int d = 1; d < 64; d++) run_row(2, 6'(d), 1'b1);

    // Start held through a whole run, delta changed mid-sweep
    wait_idle();
    @(negedge clk);
    mode_r    = 2;
    bus.delta = 6'h07;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(model(2, 6'h07, acc, 1'b0));
    sb.push_back(model(2, 6'h22, acc + 131, 1'b0));
    repeat (20) @(negedge clk);
    bus.delta = 6'h22;
    repeat (140) @(negedge clk);
    bus.start = 1'b0;
    wait_not_busy();

    // Reset in the middle of the sweep
    wait_idle();
    @(negedge clk);
    mode_r    = 0;
    bus.delta = 6'h05;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_row(0, 6'h01, 1'b1);

    for (int k = 0; k < 6; k++) run_row(int'($urandom_range(0, 2)), 6'($urandom), 1'b1);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
